// File: rtl/axi_slave_mem.sv
// AXI responder backed by a word-addressed register-file RAM; independent write and read FSMs.
// Define AXI_SLAVE_STALL_EN to insert a one-cycle bubble after every W beat and every non-last R beat.
module axi_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [31:0]           WDATA,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic                  BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [31:0]           RDATA,
  output logic                  RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [31:0] r_mem [MEM_DEPTH];

  function automatic logic inRange(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1:IDX_W+2] == '0;
  endfunction

  // Reserved burst, oversize beats and WRAP with an illegal length poison the whole burst.
  function automatic logic burstBad(input logic [7:0] len, input logic [2:0] size,
                                    input logic [1:0] burst);
    return (burst == 2'b11) || (size > 3'd2) ||
           ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] nextAddr(input logic [ADDR_WIDTH-1:0] addr,
                                                     input logic [7:0] len, input logic [2:0] size,
                                                     input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] mask;
    incr = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   nextAddr = addr;
      2'b10:   nextAddr = (addr & ~mask) | ((addr + incr) & mask);
      default: nextAddr = addr + incr;
    endcase
  endfunction

  function automatic logic [32:0] beatData(input logic [ADDR_WIDTH-1:0] addr, input logic bad);
    if (bad || !inRange(addr)) return {1'b1, 32'h0};
    return {1'b0, r_mem[addr[IDX_W+1:2]]};
  endfunction

  logic [1:0]            r_wState;
  logic [ADDR_WIDTH-1:0] r_wAddr;
  logic [7:0]            r_wLen;
  logic [2:0]            r_wSize;
  logic [1:0]            r_wBurst;
  logic [7:0]            r_wCount;
  logic                  r_wErr;
  logic                  w_wFire;
  logic                  w_wLastCnt;
  logic                  w_wInRange;
  logic [ADDR_WIDTH-1:0] w_wNextAddr;

  assign AWREADY     = (r_wState == W_IDLE);
  assign BVALID      = (r_wState == W_RESP);
  assign BRESP       = (r_wState == W_RESP) && r_wErr;
  assign w_wFire     = WVALID && WREADY;
  assign w_wLastCnt  = (r_wCount == r_wLen);
  assign w_wInRange  = inRange(r_wAddr);
  assign w_wNextAddr = nextAddr(r_wAddr, r_wLen, r_wSize, r_wBurst);

`ifdef AXI_SLAVE_STALL_EN
  logic r_wStall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_wStall <= 1'b0;
    else       r_wStall <= w_wFire;
  end

  assign WREADY = (r_wState == W_DATA) && !r_wStall;
`else
  assign WREADY = (r_wState == W_DATA);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wState <= W_IDLE;
      r_wAddr  <= '0;
      r_wLen   <= '0;
      r_wSize  <= '0;
      r_wBurst <= '0;
      r_wCount <= '0;
      r_wErr   <= 1'b0;
    end else begin
      case (r_wState)
        W_IDLE: if (AWVALID) begin
          r_wAddr  <= AWADDR;
          r_wLen   <= AWLEN;
          r_wSize  <= AWSIZE;
          r_wBurst <= AWBURST;
          r_wCount <= '0;
          r_wErr   <= burstBad(AWLEN, AWSIZE, AWBURST);
          r_wState <= W_DATA;
        end
        W_DATA: if (w_wFire) begin
          r_wAddr  <= w_wNextAddr;
          r_wCount <= r_wCount + 8'd1;
          if (!w_wInRange || (WLAST != w_wLastCnt)) r_wErr <= 1'b1;
          if (WLAST || w_wLastCnt) r_wState <= W_RESP;
        end
        W_RESP: if (BREADY) r_wState <= W_IDLE;
        default: r_wState <= W_IDLE;
      endcase
    end
  end

  // Contents survive reset so beats that landed before an abort stay visible.
  always_ff @(posedge clk) begin
    if (w_wFire && !r_wErr && w_wInRange) r_mem[r_wAddr[IDX_W+1:2]] <= WDATA;
  end

  logic [0:0]            r_rState;
  logic [ADDR_WIDTH-1:0] r_rAddr;
  logic [7:0]            r_rLen;
  logic [2:0]            r_rSize;
  logic [1:0]            r_rBurst;
  logic [7:0]            r_rCount;
  logic                  r_rBad;
  logic [31:0]           r_rData;
  logic                  r_rResp;
  logic                  r_rLast;
  logic                  r_rValid;
  logic                  w_arBad;
  logic [ADDR_WIDTH-1:0] w_rNextAddr;

  assign ARREADY     = (r_rState == R_IDLE);
  assign RDATA       = r_rData;
  assign RRESP       = r_rResp;
  assign RLAST       = r_rLast;
  assign RVALID      = r_rValid;
  assign w_arBad     = burstBad(ARLEN, ARSIZE, ARBURST);
  assign w_rNextAddr = nextAddr(r_rAddr, r_rLen, r_rSize, r_rBurst);

`ifdef AXI_SLAVE_STALL_EN
  logic r_rGap;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rState <= R_IDLE;
      r_rAddr  <= '0;
      r_rLen   <= '0;
      r_rSize  <= '0;
      r_rBurst <= '0;
      r_rCount <= '0;
      r_rBad   <= 1'b0;
      r_rData  <= '0;
      r_rResp  <= 1'b0;
      r_rLast  <= 1'b0;
      r_rValid <= 1'b0;
`ifdef AXI_SLAVE_STALL_EN
      r_rGap   <= 1'b0;
`endif
    end else begin
      case (r_rState)
        R_IDLE: if (ARVALID) begin
          r_rAddr              <= ARADDR;
          r_rLen               <= ARLEN;
          r_rSize              <= ARSIZE;
          r_rBurst             <= ARBURST;
          r_rBad               <= w_arBad;
          r_rCount             <= '0;
          {r_rResp, r_rData}   <= beatData(ARADDR, w_arBad);
          r_rLast              <= (ARLEN == 8'd0);
          r_rValid             <= 1'b1;
          r_rState             <= R_DATA;
        end
        R_DATA: begin
`ifdef AXI_SLAVE_STALL_EN
          if (r_rGap) begin
            {r_rResp, r_rData} <= beatData(r_rAddr, r_rBad);
            r_rLast            <= (r_rCount == r_rLen);
            r_rValid           <= 1'b1;
            r_rGap             <= 1'b0;
          end else
`endif
          if (r_rValid && RREADY) begin
            if (r_rLast) begin
              r_rValid <= 1'b0;
              r_rLast  <= 1'b0;
              r_rState <= R_IDLE;
            end else begin
              r_rAddr  <= w_rNextAddr;
              r_rCount <= r_rCount + 8'd1;
`ifdef AXI_SLAVE_STALL_EN
              r_rValid <= 1'b0;
              r_rGap   <= 1'b1;
`else
              {r_rResp, r_rData} <= beatData(w_rNextAddr, r_rBad);
              r_rLast            <= ((r_rCount + 8'd1) == r_rLen);
`endif
            end
          end
        end
        default: r_rState <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem: burst types, error responses,
// read backpressure and reset in the middle of a write burst.
module tb_axi_slave_mem;

  logic        clk;
  logic        reset;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic        BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic        RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  int assertCount;
  int failCount;
  logic [31:0] wrData [16];
  logic [31:0] rdExp  [16];

  axi_slave_mem #(.ADDR_WIDTH(32), .MEM_DEPTH(256)) dut (
    .clk(clk), .reset(reset),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sendAw(input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    while (!AWREADY && n < 100) begin @(posedge clk); #1; n++; end
    checkOutput("awready", 32'(AWREADY), 32'd1);
    @(posedge clk); #1;
    AWVALID = 1'b0;
  endtask

  task automatic sendW(input logic [31:0] data, input logic last);
    int n = 0;
    WDATA = data; WLAST = last; WVALID = 1'b1;
    while (!WREADY && n < 100) begin @(posedge clk); #1; n++; end
    checkOutput("wready", 32'(WREADY), 32'd1);
    @(posedge clk); #1;
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic getB(input string tag, input logic expResp);
    int n = 0;
    BREADY = 1'b1;
    while (!BVALID && n < 100) begin @(posedge clk); #1; n++; end
    checkOutput("bvalid", 32'(BVALID), 32'd1);
    checkOutput(tag, 32'(BRESP), 32'(expResp));
    @(posedge clk); #1;
    BREADY = 1'b0;
  endtask

  task automatic writeBurst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic expResp);
    sendAw(addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) sendW(wrData[i], i == int'(len));
    getB(tag, expResp);
  endtask

  task automatic sendAr(input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    while (!ARREADY && n < 100) begin @(posedge clk); #1; n++; end
    checkOutput("arready", 32'(ARREADY), 32'd1);
    @(posedge clk); #1;
    ARVALID = 1'b0;
  endtask

  task automatic recvBeat(input string tag, input logic [31:0] expData,
                          input logic expResp, input logic expLast);
    int n = 0;
    RREADY = 1'b1;
    while (!RVALID && n < 100) begin @(posedge clk); #1; n++; end
    checkOutput("rvalid", 32'(RVALID), 32'd1);
    checkOutput(tag, RDATA, expData);
    checkOutput("rresp", 32'(RRESP), 32'(expResp));
    checkOutput("rlast", 32'(RLAST), 32'(expLast));
    @(posedge clk); #1;
  endtask

  task automatic readBurst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic expResp);
    sendAr(addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) recvBeat(tag, rdExp[i], expResp, i == int'(len));
    RREADY = 1'b0;
  endtask

  task automatic applyStimulus();
    int n;
    // Reset state.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rst_awready", 32'(AWREADY), 32'd1);
    checkOutput("rst_arready", 32'(ARREADY), 32'd1);
    checkOutput("rst_wready",  32'(WREADY),  32'd0);
    checkOutput("rst_bvalid",  32'(BVALID),  32'd0);
    checkOutput("rst_bresp",   32'(BRESP),   32'd0);
    checkOutput("rst_rvalid",  32'(RVALID),  32'd0);
    checkOutput("rst_rlast",   32'(RLAST),   32'd0);
    checkOutput("rst_rresp",   32'(RRESP),   32'd0);
    checkOutput("rst_rdata",   RDATA,        32'd0);

    // INCR write then read of words 4..7.
    wrData[0] = 32'hA0; wrData[1] = 32'hA1; wrData[2] = 32'hA2; wrData[3] = 32'hA3;
    writeBurst("b_incr", 32'h10, 8'd3, 3'd2, 2'b01, 1'b0);
    rdExp[0] = 32'hA0; rdExp[1] = 32'hA1; rdExp[2] = 32'hA2; rdExp[3] = 32'hA3;
    readBurst("rd_incr", 32'h10, 8'd3, 3'd2, 2'b01, 1'b0);

    // Same read, master stalls for 3 cycles with beat 1 on the bus.
    sendAr(32'h10, 8'd3, 3'd2, 2'b01);
    recvBeat("rd_stall0", 32'hA0, 1'b0, 1'b0);
    RREADY = 1'b0;
    n = 0;
    while (!RVALID && n < 100) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold_rvalid", 32'(RVALID), 32'd1);
      checkOutput("hold_rdata",  RDATA,       32'hA1);
      checkOutput("hold_rlast",  32'(RLAST),  32'd0);
      @(posedge clk); #1;
    end
    recvBeat("rd_stall1", 32'hA1, 1'b0, 1'b0);
    recvBeat("rd_stall2", 32'hA2, 1'b0, 1'b0);
    recvBeat("rd_stall3", 32'hA3, 1'b0, 1'b1);
    RREADY = 1'b0;
    checkOutput("post_rvalid", 32'(RVALID), 32'd0);

    // WRAP from 0x18: beats land at words 6,7,4,5.
    wrData[0] = 32'd1; wrData[1] = 32'd2; wrData[2] = 32'd3; wrData[3] = 32'd4;
    writeBurst("b_wrap", 32'h18, 8'd3, 3'd2, 2'b10, 1'b0);
    rdExp[0] = 32'd1; rdExp[1] = 32'd2; rdExp[2] = 32'd3; rdExp[3] = 32'd4;
    readBurst("rd_wrap", 32'h18, 8'd3, 3'd2, 2'b10, 1'b0);
    rdExp[0] = 32'd3; rdExp[1] = 32'd4; rdExp[2] = 32'd1; rdExp[3] = 32'd2;
    readBurst("rd_wrap_lin", 32'h10, 8'd3, 3'd2, 2'b01, 1'b0);

    // FIXED: last beat wins.
    wrData[0] = 32'd5; wrData[1] = 32'd6; wrData[2] = 32'd7;
    writeBurst("b_fixed", 32'h20, 8'd2, 3'd2, 2'b00, 1'b0);
    rdExp[0] = 32'd7;
    readBurst("rd_fixed", 32'h20, 8'd0, 3'd2, 2'b01, 1'b0);

    // Out-of-range write must not alias onto word 0.
    wrData[0] = 32'h1234;
    writeBurst("b_word0", 32'h0, 8'd0, 3'd2, 2'b01, 1'b0);
    wrData[0] = 32'hDEAD;
    writeBurst("b_oor", 32'h400, 8'd0, 3'd2, 2'b01, 1'b1);
    rdExp[0] = 32'h1234;
    readBurst("rd_word0", 32'h0, 8'd0, 3'd2, 2'b01, 1'b0);
    rdExp[0] = 32'h0;
    readBurst("rd_oor", 32'h400, 8'd0, 3'd2, 2'b01, 1'b1);

    // WLAST earlier than AWLEN ends the burst with SLVERR.
    sendAw(32'h60, 8'd1, 3'd2, 2'b01);
    sendW(32'h77, 1'b1);
    getB("b_wlast_early", 1'b1);

    // Reserved read burst type.
    rdExp[0] = 32'h0;
    readBurst("rd_resv", 32'h10, 8'd0, 3'd2, 2'b11, 1'b1);

    // Reset after 2 of 4 beats.
    sendAw(32'h40, 8'd3, 3'd2, 2'b01);
    sendW(32'hB0, 1'b0);
    sendW(32'hB1, 1'b0);
    reset = 1'b1;
    #2;
    checkOutput("abort_bvalid",  32'(BVALID),  32'd0);
    checkOutput("abort_wready",  32'(WREADY),  32'd0);
    checkOutput("abort_awready", 32'(AWREADY), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    rdExp[0] = 32'hB0; rdExp[1] = 32'hB1;
    readBurst("rd_abort", 32'h40, 8'd1, 3'd2, 2'b01, 1'b0);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset   = 1'b1;
    AWADDR  = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA   = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR  = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY  = 1'b0;
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- AXI responder (slave) with an internal word-addressed register-file memory. It is the far end of the team's axi_master on the same five channels (AW/W/B/AR/R).
- Write path and read path are independent FSMs and may run concurrently.
- Used as the memory model and bring-up target for master-side integration, and as a simple on-chip scratch RAM.

Parameters:
- ADDR_WIDTH, 32, width of AWADDR/ARADDR.
- MEM_DEPTH, 256, number of 32-bit words; must be a power of 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- AWADDR  in  ADDR_WIDTH  write address
- AWLEN  in  8  beats-1
- AWSIZE  in  3  bytes/beat = 1<<AWSIZE
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- AWVALID  in  1 / AWREADY  out  1
- WDATA  in  32 / WLAST  in  1 / WVALID  in  1 / WREADY  out  1
- BRESP  out  1  0 OKAY, 1 SLVERR / BVALID  out  1 / BREADY  in  1
- ARADDR  in  ADDR_WIDTH / ARLEN  in  8 / ARSIZE  in  3 / ARBURST  in  2 / ARVALID  in  1 / ARREADY  out  1
- RDATA  out  32 / RRESP  out  1 / RLAST  out  1 / RVALID  out  1 / RREADY  in  1

Behaviour:
- Clocking and reset: clk is the clock; reset is asynchronous, active-high.
- Reset values: AWREADY=1, ARREADY=1 (Moore decode of IDLE). WREADY, BVALID, BRESP, RVALID, RLAST, RRESP = 0. RDATA = 0.
- Reset and memory: memory contents are NOT cleared by reset. Reset mid-burst aborts both FSMs to IDLE. Beats already written are retained.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1, WREADY=0. On AWVALID&AWREADY, latch addr/len/size/burst, clear beat count and error flag, go to W_DATA. AWREADY drops the next cycle.
  - W_DATA: WREADY=1. Each W handshake writes the full 32-bit WDATA to mem[addr>>2] (no strobes) unless the error flag or out-of-range applies. Then the address advances and the beat count increments.
  - W_DATA exit: the burst ends on the handshake where WLAST=1 or where beat count == AWLEN. If WLAST and the count disagree, the error flag is set and the burst ends at whichever comes first. On exit: WREADY=0, BVALID=1, go to W_RESP.
  - W_RESP: hold BVALID and BRESP stable until BREADY. Then BVALID=0, return to W_IDLE.
- Write error flag (sticky for the burst, forces BRESP=1): any beat address with (addr>>2) >= MEM_DEPTH suppresses that write; AWBURST=11 or AWSIZE>2 suppresses all writes in the burst; WLAST/count mismatch.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On AR handshake, latch fields and load beat 0. RVALID=1 the next cycle, with RDATA=mem[addr>>2].
  - R_DATA: RVALID, RDATA, RRESP and RLAST are held stable while RREADY=0.
  - Handshake on a non-last beat: load the next beat on the same edge, so RVALID stays 1 and back-to-back beats give 1 beat/clk.
  - Handshake on the last beat: RVALID=0, RLAST=0, return to R_IDLE.
  - RLAST=1 exactly on beat ARLEN.
  - Out-of-range beat: RDATA=0, RRESP=1. Reserved burst or ARSIZE>2: every beat returns RDATA=0, RRESP=1.
- Address step, with incr=1<<size:
  - FIXED: address unchanged.
  - INCR: addr+incr, ADDR_WIDTH wrap-around.
  - WRAP: bound=(len+1)*incr; next = (addr & ~(bound-1)) | ((addr+incr) & (bound-1)). len other than 1/3/7/15 makes the burst an error.
- Same-address read and write on the same edge: the read returns the old value.
- W beats arriving before AW are not accepted (WREADY=0 in W_IDLE).

Optional Feature:
- AXI_SLAVE_STALL_EN defined:
  - After every accepted W beat, WREADY is forced low for exactly 1 cycle.
  - After every accepted non-last R beat, RVALID is forced low for 1 cycle before the next beat is presented.
  - Throughput is 1 beat per 2 clk; this exercises master backpressure handling.
- Undefined: no stall insertion; full 1 beat/clk throughput.

Test Plan:
- INCR write AWADDR=0x10 AWLEN=3 AWSIZE=2, data 0xA0,0xA1,0xA2,0xA3, then INCR read of the same range -> BRESP=0; RDATA A0..A3; RLAST only on 4th beat; RRESP=0.
- WRAP write AWADDR=0x18 len=3 size=2, data 1,2,3,4 -> mem words 6,7,4,5 = 1,2,3,4; read WRAP from 0x18 returns 1,2,3,4.
- FIXED write AWADDR=0x20 len=2, data 5,6,7 -> mem[8]=7, BRESP=0.
- Out-of-range write AWADDR=0x400 (MEM_DEPTH=256), 1 beat -> BRESP=1, memory unchanged; read ARADDR=0x400 -> RDATA=0, RRESP=1, RLAST=1.
- INCR read len=3, RREADY low for 3 cycles after beat 1 -> RVALID/RDATA/RLAST stable during stall, all 4 beats delivered in order.
- Reset pulse after 2 of 4 write beats (data 0xB0,0xB1 to 0x40) -> BVALID=0, WREADY=0, AWREADY=1; later read of 0x40,0x44 returns 0xB0,0xB1.
